// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave controller and its wait-state counter.
package apb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state countdown: loaded at APB setup, decremented once per ACCESS cycle.
module apb_wait_counter
  import apb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave front end: captures each transfer, inserts wait states, decodes errors
// and turns the access phase into single-cycle register-file strobes.
module apb_slave_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_LIMIT  = 'h040
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                wr_en,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_be,
  input  logic [DATA_W-1:0]   reg_rdata
);

  localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W + 1)'(ADDR_LIMIT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W/8-1:0] be_reg;
  logic                write_reg;
  logic                err_reg;

  logic capture;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic addr_err;

  // Out-of-range or not aligned to the bus width.
  assign addr_err = ({1'b0, paddr} >= LIMIT) || ((paddr & ALIGN_MASK) != '0);

  apb_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        addr_reg  <= paddr;
        wdata_reg <= pwdata;
        be_reg    <= pstrb;
        write_reg <= pwrite;
        err_reg   <= addr_err;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (psel && !penable) begin
          capture    = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_ACCESS;
        end else if (psel && penable) begin
          // Access phase with no setup seen: answer with an error, stay idle.
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_next = ST_IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (penable) begin
          pready     = 1'b1;
          state_next = ST_IDLE;
          if (err_reg) begin
            pslverr = 1'b1;
          end else begin
            wr_en = write_reg;
            rd_en = !write_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register-file bus is quiet outside of a transfer.
  assign reg_addr  = (state_reg == ST_ACCESS) ? addr_reg  : '0;
  assign reg_wdata = (state_reg == ST_ACCESS) ? wdata_reg : '0;
  assign reg_be    = (state_reg == ST_ACCESS) ? be_reg    : '0;
  assign prdata    = rd_en ? reg_rdata : '0;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Scoreboard bench: three controllers (0, 3 and 2 wait states) on a shared APB bus,
// one selected at a time; the driver queues expectations, the monitor checks responses.
module tb_apb_slave_ctrl;

  localparam int NDUT = 3;

  typedef struct {
    int          exp_cyc;
    logic        wr;
    logic        rd;
    logic        err;
    logic        chk_bus;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] prdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] rdata_drive = '0;

  logic [31:0] prdata_w    [NDUT];
  logic        pready_w    [NDUT];
  logic        pslverr_w   [NDUT];
  logic        wr_w        [NDUT];
  logic        rd_w        [NDUT];
  logic [11:0] reg_addr_w  [NDUT];
  logic [31:0] reg_wdata_w [NDUT];
  logic [3:0]  reg_be_w    [NDUT];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   sel     = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      apb_slave_ctrl #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .WAIT_CYCLES ((gi == 0) ? 0 : (gi == 1) ? 3 : 2),
        .ADDR_LIMIT  ('h040)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata_w[gi]),
        .pready    (pready_w[gi]),
        .pslverr   (pslverr_w[gi]),
        .wr_en     (wr_w[gi]),
        .rd_en     (rd_w[gi]),
        .reg_addr  (reg_addr_w[gi]),
        .reg_wdata (reg_wdata_w[gi]),
        .reg_be    (reg_be_w[gi]),
        .reg_rdata (rdata_drive)
      );
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Monitor: any response or strobe on the selected controller retires one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (pready_w[d] === 1'b0 && pslverr_w[d] === 1'b1) begin
        n_fail++;
        $display("[TB] FAIL slverr_without_ready dut%0d: pslverr=1, expected 0 while pready=0", d);
      end
    end
    if (pready_w[sel] === 1'b1 || wr_w[sel] === 1'b1 || rd_w[sel] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_response dut%0d cyc %0d: pready=%b wr=%b rd=%b, expected none",
                 sel, cyc, pready_w[sel], wr_w[sel], rd_w[sel]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency_cycle", 64'(cyc), 64'(e.exp_cyc));
        check("pready", 64'(pready_w[sel]), 64'(1'b1));
        check("pslverr", 64'(pslverr_w[sel]), 64'(e.err));
        check("strobes_wr_rd", 64'({wr_w[sel], rd_w[sel]}), 64'({e.wr, e.rd}));
        check("prdata", 64'(prdata_w[sel]), 64'(e.prdata));
        if (e.chk_bus)
          check("reg_addr_wdata_be", {16'h0, reg_addr_w[sel], reg_wdata_w[sel], reg_be_w[sel]},
                {16'h0, e.addr, e.wdata, e.be});
        $display("[TB] txn dut%0d cyc %0d addr 'h%03h wr=%b rd=%b err=%b prdata 'h%08h",
                 sel, cyc, reg_addr_w[sel], wr_w[sel], rd_w[sel], pslverr_w[sel], prdata_w[sel]);
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
  endtask

  // Full APB transfer; paddr/pwdata are scrambled during ACCESS to prove capture.
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] rdata, input logic err);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    sel         = d;
    psel        = 1'b1;
    penable     = 1'b0;
    pwrite      = wr;
    paddr       = addr;
    pwdata      = wdata;
    pstrb       = strb;
    rdata_drive = rdata;
    e.exp_cyc   = cyc + 1 + wait_of(d);
    e.wr        = wr && !err;
    e.rd        = !wr && !err;
    e.err       = err;
    e.chk_bus   = !err;
    e.addr      = addr;
    e.wdata     = wdata;
    e.be        = strb;
    e.prdata    = (!wr && !err) ? rdata : 32'h0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~wdata;
    done    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pready_w[d] === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL pready_timeout dut%0d addr 'h%03h: pready=0, expected 1 within 20 cycles", d, addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check("reset_outputs", {pready_w[d], pslverr_w[d], wr_w[d], rd_w[d], prdata_w[d], reg_addr_w[d]},
            64'h0);

    // Zero-wait write.
    apb_xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    idle_cycle();
    // Three wait states, read.
    apb_xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 32'h12345678, 1'b0);
    idle_cycle();
    // Out-of-range write, misaligned read.
    apb_xfer(0, 1'b1, 12'h040, 32'h11111111, 4'hF, 32'h0, 1'b1);
    idle_cycle();
    apb_xfer(0, 1'b0, 12'h006, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);
    idle_cycle();
    // Back-to-back write then read, no idle gap.
    apb_xfer(0, 1'b1, 12'h000, 32'h0BADF00D, 4'h5, 32'h0, 1'b0);
    apb_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    idle_cycle();
    @(negedge clk);
    check("idle_bus_quiet", {16'h0, reg_addr_w[0], reg_wdata_w[0], reg_be_w[0]}, 64'h0);
    // Write with no byte strobes still commits.
    apb_xfer(0, 1'b1, 12'h010, 32'h76543210, 4'h0, 32'h0, 1'b0);
    idle_cycle();

    // Reset in first wait cycle, then penable held: orphan error response.
    @(posedge clk); #1;
    sel     = 2;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h020;
    pwdata  = 32'h99999999;
    pstrb   = 4'hF;
    begin
      exp_t e;
      e.exp_cyc = cyc + 2;
      e.wr      = 1'b0;
      e.rd      = 1'b0;
      e.err     = 1'b1;
      e.chk_bus = 1'b1;
      e.addr    = 12'h0;
      e.wdata   = 32'h0;
      e.be      = 4'h0;
      e.prdata  = 32'h0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    penable = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    idle_cycle();

    // Abort: psel dropped during a wait cycle, then a normal read.
    @(posedge clk); #1;
    sel     = 1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h030;
    pwdata  = 32'h44444444;
    pstrb   = 4'hF;
    idle_cycle();
    apb_xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
    idle_cycle();
    // Last valid word below the limit, two wait states.
    apb_xfer(2, 1'b1, 12'h03C, 32'hFEEDC0DE, 4'hC, 32'h0, 1'b0);
    repeat (5) idle_cycle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
